// File: rtl/spi_cmd_sequencer.sv
// Pops commands from a show-ahead SPI command queue and sequences them onto the SPI master.
// Chain-write commands expand into a base transfer plus one transfer per set device-mask bit.
module spi_cmd_sequencer #(
  parameter int          N_DEV   = 4,
  parameter int          DEV_W   = 2,
  parameter int          TMO_CYC = 4096,
  parameter logic [2:0]  OP_CW   = 3'b100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [2:0]            q_op,
  input  logic [9:0]            q_addr,
  input  logic [12:0]           q_low13,
  input  logic [47:0]           q_wdata,
  input  logic [59:0]           q_std,
  input  logic [N_DEV-1:0]      q_cw_mask,
  input  logic [10*N_DEV-1:0]   q_cw_addr,
  input  logic [48*N_DEV-1:0]   q_cw_wdata,
  input  logic                  spi_ready,
  output logic                  spi_start,
  output logic [2:0]            spi_op,
  output logic [9:0]            spi_addr,
  output logic [12:0]           spi_low13,
  output logic [47:0]           spi_wdata,
  output logic [59:0]           spi_std,
  output logic [DEV_W-1:0]      spi_dev,
  input  logic                  spi_done,
  output logic                  cmpl_valid,
  output logic                  cmpl_err,
  output logic [3:0]            cmpl_xfers,
  output logic                  busy
);

  localparam int              WD_W    = $clog2(TMO_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]          op_r;
  logic [9:0]          addr_r;
  logic [12:0]         low13_r;
  logic [47:0]         wdata_r;
  logic [59:0]         std_r;
  logic [DEV_W-1:0]    dev_r;
  logic [10*N_DEV-1:0] cw_addr_r;
  logic [48*N_DEV-1:0] cw_wdata_r;
  logic [N_DEV-1:0]    rem;
  logic [3:0]          xfer_cnt;
  logic [WD_W-1:0]     wdog;
  logic                err_r;

  logic [DEV_W-1:0]    lo_idx;
  logic [N_DEV-1:0]    lo_bit;

  // Lowest pending device: scanning downward lets the lowest set bit win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    lo_idx = '0;
    lo_bit = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (rem[i]) begin
        lo_idx    = DEV_W'(i);
        lo_bit    = '0;
        lo_bit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    q_ready    = 1'b0;
    spi_start  = 1'b0;
    cmpl_valid = 1'b0;
    cmpl_err   = 1'b0;
    cmpl_xfers = '0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        q_ready = 1'b1;
        if (q_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        spi_start = spi_ready;
        if (spi_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done in the timeout cycle takes priority over the watchdog.
        if (spi_done)              state_nxt = (rem != '0) ? S_ISSUE : S_DONE;
        else if (wdog == WD_LAST)  state_nxt = S_DONE;
      end
      S_DONE: begin
        cmpl_valid = 1'b1;
        cmpl_err   = err_r;
        cmpl_xfers = xfer_cnt;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the latched command fields are cleared on reset too, so outputs read 0 out of reset.
    if (rst) begin
      op_r       <= '0;
      addr_r     <= '0;
      low13_r    <= '0;
      wdata_r    <= '0;
      std_r      <= '0;
      dev_r      <= '0;
      cw_addr_r  <= '0;
      cw_wdata_r <= '0;
      rem        <= '0;
      xfer_cnt   <= '0;
      wdog       <= '0;
      err_r      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (q_valid) begin
            op_r       <= q_op;
            addr_r     <= q_addr;
            low13_r    <= q_low13;
            wdata_r    <= q_wdata;
            std_r      <= q_std;
            cw_addr_r  <= q_cw_addr;
            cw_wdata_r <= q_cw_wdata;
            rem        <= (q_op == OP_CW) ? q_cw_mask : '0;
            dev_r      <= '0;
            xfer_cnt   <= '0;
            err_r      <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (spi_ready) begin
            xfer_cnt <= xfer_cnt + 4'd1;
            wdog     <= '0;
          end
        end
        S_WAIT: begin
          wdog <= wdog + WD_W'(1);
          if (spi_done) begin
            if (rem != '0) begin
              addr_r  <= cw_addr_r[10*int'(lo_idx) +: 10];
              wdata_r <= cw_wdata_r[48*int'(lo_idx) +: 48];
              dev_r   <= lo_idx;
              rem     <= rem & ~lo_bit;
            end
          end else if (wdog == WD_LAST) begin
            err_r <= 1'b1;
            rem   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_op    = op_r;
  assign spi_addr  = addr_r;
  assign spi_low13 = low13_r;
  assign spi_wdata = wdata_r;
  assign spi_std   = std_r;
  assign spi_dev   = dev_r;

endmodule
